// File: rtl/instr_fetch_stage_if.sv
// Instruction-memory request/acknowledge bus between the fetch stage (master)
// and instruction memory (slave).
`default_nettype none

interface instr_fetch_stage_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );
endinterface

`default_nettype wire

// File: rtl/instr_fetch_stage.sv
// ============================================================================
// Module  : instr_fetch_stage
// Purpose : Fetch stage with req/ack imem handshake, decode register, 1-entry
//           skid buffer, PCSrc redirect and wrong-path kill. Optional macro
//           MISALIGN_CHECK_EN adds a sticky misaligned-redirect error output.
// Revision: 1.0
// ============================================================================
`default_nettype none

module instr_fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic                       clk,
  input  logic                       rst,
  instr_fetch_stage_if.master        imem,
  input  logic                       stall,
  input  logic                       PCSrc,
  input  logic [31:0]                PCTarget,
  output logic                       valid_D,
  output logic [31:0]                Instr_D,
  output logic [31:0]                PC_D,
  output logic [31:0]                PCPlus4_D,
  output logic [6:0]                 Op,
  output logic [2:0]                 funct3,
  output logic [6:0]                 funct7
`ifdef MISALIGN_CHECK_EN
  ,
  output logic                       misalign_err
`endif
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_FULL = 2'd2;

  logic [1:0]  state;
  logic [31:0] pc_f;
  logic [31:0] req_addr;
  logic [31:0] instr_q;
  logic [31:0] skid_instr;
  logic [31:0] skid_pc;
  logic        skid_valid;
  logic        kill;
  logic        err_q;

  logic [31:0] tgt;
  logic        tgt_bad;
  logic        redirect;
  logic        advance;

`ifdef MISALIGN_CHECK_EN
  assign tgt          = PCTarget;
  assign tgt_bad      = |PCTarget[1:0];
  assign misalign_err = err_q;
`else
  assign tgt     = {PCTarget[31:2], 2'b00};
  assign tgt_bad = 1'b0;
  logic unused_tgt_lsb;
  assign unused_tgt_lsb = ^PCTarget[1:0];
`endif

  assign redirect = PCSrc && valid_D;
  assign advance  = !valid_D || !stall;

  assign imem.imem_req  = (state == S_REQ);
  assign imem.imem_addr = req_addr;

  assign Instr_D   = valid_D ? instr_q : NOP_INSTR;
  assign PCPlus4_D = PC_D + 32'd4;
  assign Op        = Instr_D[6:0];
  assign funct3    = Instr_D[14:12];
  assign funct7    = Instr_D[31:25];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      pc_f       <= RESET_PC;
      req_addr   <= RESET_PC;
      valid_D    <= 1'b0;
      instr_q    <= NOP_INSTR;
      PC_D       <= 32'd0;
      skid_instr <= NOP_INSTR;
      skid_pc    <= 32'd0;
      skid_valid <= 1'b0;
      kill       <= 1'b0;
      err_q      <= 1'b0;
    end else if (redirect) begin
      valid_D    <= 1'b0;
      skid_valid <= 1'b0;
      pc_f       <= tgt;
      if (tgt_bad) begin
        err_q <= 1'b1;
        kill  <= 1'b0;
        state <= S_IDLE;
      end else if ((state == S_REQ) && !imem.imem_ack) begin
        // Request must stay stable until its ack; that ack is then dropped.
        kill <= 1'b1;
      end else begin
        kill     <= 1'b0;
        state    <= S_REQ;
        req_addr <= tgt;
      end
    end else begin
      if (advance) begin
        valid_D <= 1'b0;
      end
      case (state)
        S_IDLE: begin
          if (!err_q) begin
            state    <= S_REQ;
            req_addr <= pc_f;
          end
        end
        S_REQ: begin
          if (imem.imem_ack) begin
            if (kill) begin
              kill     <= 1'b0;
              req_addr <= pc_f;
            end else begin
              pc_f <= pc_f + 32'd4;
              if (advance && !skid_valid) begin
                instr_q  <= imem.imem_rdata;
                PC_D     <= req_addr;
                valid_D  <= 1'b1;
                req_addr <= pc_f + 32'd4;
              end else begin
                skid_instr <= imem.imem_rdata;
                skid_pc    <= req_addr;
                skid_valid <= 1'b1;
                state      <= S_FULL;
              end
            end
          end
        end
        S_FULL: begin
          if (advance) begin
            instr_q    <= skid_instr;
            PC_D       <= skid_pc;
            valid_D    <= 1'b1;
            skid_valid <= 1'b0;
            state      <= S_REQ;
            req_addr   <= pc_f;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire
